pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg.sv | 119 +++++++++++
 tb/tb_pipe_stage_reg.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : Valid/ready pipeline stage register with flush, optional
//            two-entry skid buffer, occupancy and saturating stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int WIDTH   = 115,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_payload,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_payload,
    input  logic             flush,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    // State encoding doubles as the occupancy count.
    localparam logic [1:0]       c_S_EMPTY  = 2'd0;
    localparam logic [1:0]       c_S_ONE    = 2'd1;
    localparam logic [1:0]       c_S_TWO    = 2'd2;
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state_q, w_state_d;
    logic [WIDTH-1:0] r_main_q,  w_main_d;
    logic [WIDTH-1:0] r_skid_q,  w_skid_d;
    logic [CNT_W-1:0] r_stall_q, w_stall_d;
    logic             w_main_valid;
    logic             w_push;
    logic             w_pop;

    assign w_main_valid = (r_state_q != c_S_EMPTY);

    generate
        if (SKID_EN != 0) begin : g_skid_ready
            logic w_skid_valid;
            assign w_skid_valid = (r_state_q == c_S_TWO);
            assign in_ready     = !w_skid_valid && !reset;
        end else begin : g_comb_ready
            assign in_ready = (!w_main_valid || out_ready) && !reset;
        end
    endgenerate

    assign w_push = in_valid && in_ready;
    assign w_pop  = w_main_valid && out_ready;

    always_comb begin
        w_state_d = r_state_q;
        w_main_d  = r_main_q;
        w_skid_d  = r_skid_q;
        if (flush) begin
            w_state_d = c_S_EMPTY;
        end else begin
            case (r_state_q)
                c_S_EMPTY: begin
                    if (w_push) begin
                        w_state_d = c_S_ONE;
                        w_main_d  = in_payload;
                    end
                end
                c_S_ONE: begin
                    // Without the skid buffer a push here always pairs with a pop.
                    if (w_push && w_pop) begin
                        w_main_d = in_payload;
                    end else if (w_push) begin
                        w_state_d = c_S_TWO;
                        w_skid_d  = in_payload;
                    end else if (w_pop) begin
                        w_state_d = c_S_EMPTY;
                    end
                end
                c_S_TWO: begin
                    if (w_pop) begin
                        w_state_d = c_S_ONE;
                        w_main_d  = r_skid_q;
                    end
                end
                default: w_state_d = c_S_EMPTY;
            endcase
        end
    end

    always_comb begin
        w_stall_d = r_stall_q;
        if (w_main_valid && !out_ready && (r_stall_q != c_CNT_MAX)) begin
            w_stall_d = r_stall_q + c_CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= c_S_EMPTY;
            r_main_q  <= '0;
            r_skid_q  <= '0;
            r_stall_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_main_q  <= w_main_d;
            r_skid_q  <= w_skid_d;
            r_stall_q <= w_stall_d;
        end
    end

    assign out_valid   = w_main_valid;
    assign out_payload = r_main_q;
    assign occupancy   = r_state_q;
    assign stall_cnt   = r_stall_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Brief    : Self-checking bench for pipe_stage_reg (skid, no-skid and
//            narrow-counter instances driven by shared stimulus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int W = 115;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic [W-1:0] in_payload;
    logic         out_ready;
    logic         flush;

    logic         ir_s, ov_s, ir_n, ov_n, ir_c, ov_c;
    logic [W-1:0] pl_s, pl_n, pl_c;
    logic [1:0]   occ_s, occ_n, occ_c;
    logic [15:0]  st_s, st_n;
    logic [3:0]   st_c;

    int checks = 0;
    int failures = 0;

    // Reference model: a FIFO of up to two payloads per configuration.
    int           s_cnt, n_cnt;
    logic [W-1:0] s_q0, s_q1, n_q0, n_q1;
    int           s_st, c_st, n_st;

    pipe_stage_reg #(.WIDTH(W), .SKID_EN(1), .CNT_W(16)) dut_skid (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_s),
        .in_payload(in_payload), .out_valid(ov_s), .out_ready(out_ready),
        .out_payload(pl_s), .flush(flush), .occupancy(occ_s), .stall_cnt(st_s));

    pipe_stage_reg #(.WIDTH(W), .SKID_EN(0), .CNT_W(16)) dut_noskid (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_n),
        .in_payload(in_payload), .out_valid(ov_n), .out_ready(out_ready),
        .out_payload(pl_n), .flush(flush), .occupancy(occ_n), .stall_cnt(st_n));

    pipe_stage_reg #(.WIDTH(W), .SKID_EN(1), .CNT_W(4)) dut_cnt4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_c),
        .in_payload(in_payload), .out_valid(ov_c), .out_ready(out_ready),
        .out_payload(pl_c), .flush(flush), .occupancy(occ_c), .stall_cnt(st_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic mstep(input logic rdy, input logic r, input logic iv, input logic ordy,
                         input logic fl, input logic [W-1:0] pl,
                         inout int cnt, inout logic [W-1:0] q0, inout logic [W-1:0] q1);
        logic push, pop;
        push = iv && rdy;
        pop  = (cnt > 0) && ordy;
        if (r) begin
            cnt = 0; q0 = '0; q1 = '0;
        end else if (fl) begin
            cnt = 0;
        end else begin
            if (pop) begin q0 = q1; cnt--; end
            if (push) begin
                if (cnt == 0) q0 = pl; else q1 = pl;
                cnt++;
            end
        end
    endtask

    function automatic int stall_next(input int st, input int cnt, input logic r,
                                      input logic ordy, input int mx);
        if (r) return 0;
        if (cnt > 0 && !ordy && st < mx) return st + 1;
        return st;
    endfunction

    // One clock cycle: drive, check in_ready, advance model, check registered outputs.
    task automatic cycle(input logic r, input logic iv, input logic [W-1:0] pl,
                         input logic ordy, input logic fl, input int exp_sir, input int exp_nir);
        logic s_rdy, n_rdy;
        reset = r; in_valid = iv; in_payload = pl; out_ready = ordy; flush = fl;
        #1;
        s_rdy = !r && (s_cnt < 2);
        n_rdy = !r && ((n_cnt == 0) || ordy);
        chk("skid_in_ready", ir_s, s_rdy);
        chk("cnt4_in_ready", ir_c, s_rdy);
        chk("noskid_in_ready", ir_n, n_rdy);
        if (exp_sir >= 0) chk("skid_in_ready_vec", ir_s, exp_sir[0]);
        if (exp_nir >= 0) chk("noskid_in_ready_vec", ir_n, exp_nir[0]);
        s_st = stall_next(s_st, s_cnt, r, ordy, 65535);
        c_st = stall_next(c_st, s_cnt, r, ordy, 15);
        n_st = stall_next(n_st, n_cnt, r, ordy, 65535);
        mstep(s_rdy, r, iv, ordy, fl, pl, s_cnt, s_q0, s_q1);
        mstep(n_rdy, r, iv, ordy, fl, pl, n_cnt, n_q0, n_q1);
        @(posedge clk);
        #1;
        chk("skid_out_valid", ov_s, s_cnt > 0);
        chk("skid_occupancy", occ_s, s_cnt);
        chk("skid_stall_cnt", st_s, s_st);
        chk("cnt4_out_valid", ov_c, s_cnt > 0);
        chk("cnt4_occupancy", occ_c, s_cnt);
        chk("cnt4_stall_cnt", st_c, c_st);
        chk("noskid_out_valid", ov_n, n_cnt > 0);
        chk("noskid_occupancy", occ_n, n_cnt);
        chk("noskid_stall_cnt", st_n, n_st);
        if (s_cnt > 0 || r) begin
            chk("skid_payload", pl_s, s_q0);
            chk("cnt4_payload", pl_c, s_q0);
        end
        if (n_cnt > 0 || r) chk("noskid_payload", pl_n, n_q0);
    endtask

    typedef struct {
        logic       rst, iv, ordy, fl;
        logic [7:0] pl;
        logic       e_ir, e_ov;
        logic [7:0] e_pl;
        logic [1:0] e_occ;
        int         e_st;
    } vec_t;

    vec_t vecs[23];

    initial begin
        logic [W-1:0] pl;
        logic [127:0] rv;
        reset = 1'b1; in_valid = 1'b0; in_payload = '0; out_ready = 1'b0; flush = 1'b0;
        s_cnt = 0; n_cnt = 0; s_q0 = '0; s_q1 = '0; n_q0 = '0; n_q1 = '0;
        s_st = 0; c_st = 0; n_st = 0;

        //          rst iv ordy fl  pl     e_ir e_ov e_pl  occ st
        vecs[0]  = '{1, 1, 1, 0, 8'h09, 0, 0, 8'h00, 0, 0};
        vecs[1]  = '{0, 1, 1, 0, 8'h01, 1, 1, 8'h01, 1, 0};
        vecs[2]  = '{0, 1, 1, 0, 8'h02, 1, 1, 8'h02, 1, 0};
        vecs[3]  = '{0, 1, 1, 0, 8'h03, 1, 1, 8'h03, 1, 0};
        vecs[4]  = '{0, 0, 1, 0, 8'h00, 1, 0, 8'h00, 0, 0};
        vecs[5]  = '{0, 1, 0, 0, 8'h0A, 1, 1, 8'h0A, 1, 0};
        vecs[6]  = '{0, 1, 0, 0, 8'h0B, 1, 1, 8'h0A, 2, 1};
        vecs[7]  = '{0, 1, 0, 0, 8'h0C, 0, 1, 8'h0A, 2, 2};
        vecs[8]  = '{0, 0, 0, 0, 8'h00, 0, 1, 8'h0A, 2, 3};
        vecs[9]  = '{0, 0, 1, 0, 8'h00, 0, 1, 8'h0B, 1, 3};
        vecs[10] = '{0, 1, 1, 0, 8'h0C, 1, 1, 8'h0C, 1, 3};
        vecs[11] = '{0, 0, 1, 0, 8'h00, 1, 0, 8'h00, 0, 3};
        vecs[12] = '{0, 1, 0, 0, 8'h0A, 1, 1, 8'h0A, 1, 3};
        vecs[13] = '{0, 1, 0, 0, 8'h0B, 1, 1, 8'h0A, 2, 4};
        vecs[14] = '{0, 1, 0, 1, 8'h0C, 0, 0, 8'h00, 0, 5};
        vecs[15] = '{0, 1, 0, 0, 8'h0A, 1, 1, 8'h0A, 1, 5};
        vecs[16] = '{0, 1, 1, 1, 8'h0C, 1, 0, 8'h00, 0, 5};
        vecs[17] = '{0, 0, 1, 0, 8'h00, 1, 0, 8'h00, 0, 5};
        vecs[18] = '{0, 1, 0, 0, 8'h0A, 1, 1, 8'h0A, 1, 5};
        vecs[19] = '{0, 1, 0, 0, 8'h0B, 1, 1, 8'h0A, 2, 6};
        vecs[20] = '{0, 0, 0, 0, 8'h00, 0, 1, 8'h0A, 2, 7};
        vecs[21] = '{1, 1, 0, 1, 8'h0C, 0, 0, 8'h00, 0, 0};
        vecs[22] = '{0, 0, 1, 0, 8'h00, 1, 0, 8'h00, 0, 0};

        for (int i = 0; i < 23; i++) begin
            pl = '0;
            pl[7:0] = vecs[i].pl;
            cycle(vecs[i].rst, vecs[i].iv, pl, vecs[i].ordy, vecs[i].fl, int'(vecs[i].e_ir), -1);
            chk("vec_out_valid", ov_s, vecs[i].e_ov);
            chk("vec_occupancy", occ_s, vecs[i].e_occ);
            chk("vec_stall_cnt", st_s, vecs[i].e_st);
            if (vecs[i].e_ov || vecs[i].rst) chk("vec_payload", pl_s[7:0], vecs[i].e_pl);
        end

        // Single-entry mode: ready follows out_ready in the same cycle.
        cycle(0, 1, W'(5), 1, 0, -1, 1);
        chk("ns_load_payload", pl_n, W'(5));
        cycle(0, 1, W'(6), 0, 0, -1, 0);
        chk("ns_hold_payload", pl_n, W'(5));
        chk("ns_hold_occ", occ_n, 2'd1);
        cycle(0, 1, W'(6), 1, 0, -1, 1);
        chk("ns_swap_payload", pl_n, W'(6));
        chk("ns_swap_occ", occ_n, 2'd1);
        cycle(0, 0, '0, 1, 0, -1, 1);

        // Narrow counter saturation.
        cycle(1, 0, '0, 0, 0, -1, -1);
        cycle(0, 1, W'(7), 0, 0, -1, -1);
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, '0, 0, 0, -1, -1);
            chk("sat_stall_cnt", st_c, (i + 1 < 15) ? (i + 1) : 15);
        end

        // Randomized traffic against the model.
        cycle(1, 0, '0, 1, 0, -1, -1);
        for (int i = 0; i < 600; i++) begin
            rv = {$urandom, $urandom, $urandom, $urandom};
            pl = rv[W-1:0];
            cycle($urandom_range(0, 99) < 2, $urandom_range(0, 1) == 1, pl,
                  $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 6, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
